// File: rtl/fifo_ctrl_mc_if.sv
// SDRAM-side request/ack bundle for fifo_ctrl_mc.
// master drives requests, slave returns acks.
interface fifo_ctrl_mc_if #(
  parameter int ADDR_W = 24,
  parameter int LEN_W  = 10
);
  logic              sdram_wr_req;
  logic [ADDR_W-1:0] sdram_wr_addr;
  logic [LEN_W-1:0]  sdram_wr_len;
  logic              sdram_wr_ack;
  logic              sdram_rd_req;
  logic [ADDR_W-1:0] sdram_rd_addr;
  logic [LEN_W-1:0]  sdram_rd_len;
  logic              sdram_rd_ack;

  modport master (
    output sdram_wr_req, sdram_wr_addr, sdram_wr_len,
    output sdram_rd_req, sdram_rd_addr, sdram_rd_len,
    input  sdram_wr_ack, sdram_rd_ack
  );

  modport slave (
    input  sdram_wr_req, sdram_wr_addr, sdram_wr_len,
    input  sdram_rd_req, sdram_rd_addr, sdram_rd_len,
    output sdram_wr_ack, sdram_rd_ack
  );
endinterface

// File: rtl/fifo_ctrl_mc.sv
// Multi-channel SDRAM FIFO controller: arbitrates
// per-channel write/read bursts onto one SDRAM port pair.
module fifo_ctrl_mc #(
  parameter int CH_NUM = 2,
  parameter int ADDR_W = 24,
  parameter int LEN_W  = 10,
  parameter int CNT_W  = 10,
  parameter int RR_EN  = 1
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     init_end,
  input  logic [CH_NUM-1:0]        read_valid,
  input  logic [CH_NUM-1:0]        wr_rst,
  input  logic [CH_NUM-1:0]        rd_rst,
  input  logic [CH_NUM*ADDR_W-1:0] wr_b_addr,
  input  logic [CH_NUM*ADDR_W-1:0] wr_e_addr,
  input  logic [CH_NUM*ADDR_W-1:0] rd_b_addr,
  input  logic [CH_NUM*ADDR_W-1:0] rd_e_addr,
  input  logic [LEN_W-1:0]         wr_burst_len,
  input  logic [LEN_W-1:0]         rd_burst_len,
  input  logic [CH_NUM*CNT_W-1:0]  wr_fifo_num,
  input  logic [CH_NUM*CNT_W-1:0]  rd_fifo_num,
  fifo_ctrl_mc_if.master           sd,
  output logic [CH_NUM-1:0]        wr_fifo_rd_en,
  output logic [CH_NUM-1:0]        rd_fifo_wr_en,
  output logic [CH_NUM-1:0]        wr_ch_sel,
  output logic [CH_NUM-1:0]        rd_ch_sel
);

  localparam int AW1 = ADDR_W + 1;
  localparam int IW  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_BUSY, RD_REQ, RD_BUSY
  } state_t;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [LEN_W-1:0]  len_t;

  state_t            st_q, st_d;
  addr_t             wptr_q [CH_NUM];
  addr_t             wptr_d [CH_NUM];
  addr_t             rptr_q [CH_NUM];
  addr_t             rptr_d [CH_NUM];
  len_t              weff [CH_NUM];
  len_t              reff [CH_NUM];
  logic [CH_NUM-1:0] wcand, rcand;
  logic [CH_NUM-1:0] wsel_q, wsel_d, rsel_q, rsel_d;
  logic [IW-1:0]     wrr_q, wrr_d, rrr_q, rrr_d;
  logic [IW-1:0]     wpick, rpick;
  addr_t             waddr_q, waddr_d, raddr_q, raddr_d;
  len_t              wlen_q, wlen_d, rlen_q, rlen_d;
  logic              wreq_q, wreq_d, rreq_q, rreq_d;
  logic              wack_q, rack_q;
  logic              wdrop_q, wdrop_d, rdrop_q, rdrop_d;
  logic              wr_end, rd_end;

  function automatic len_t eff_len(
    input addr_t p, input addr_t e, input len_t bl
  );
    logic [AW1-1:0] room;
    len_t           r;
    room = AW1'(e) - AW1'(p);
    if (p >= e)               r = '0;
    else if (room > AW1'(bl)) r = bl;
    else                      r = room[LEN_W-1:0];
    return r;
  endfunction

  function automatic addr_t advance(
    input addr_t p, input addr_t b,
    input addr_t e, input len_t len
  );
    logic [AW1-1:0] sum;
    sum = AW1'(p) + AW1'(len);
    return (sum >= AW1'(e)) ? b : sum[ADDR_W-1:0];
  endfunction

  // First candidate at or after start, wrapping.
  function automatic logic [IW-1:0] pick(
    input logic [CH_NUM-1:0] cand,
    input logic [IW-1:0]     start
  );
    logic [IW-1:0] r;
    int            idx;
    r = '0;
    for (int k = CH_NUM - 1; k >= 0; k--) begin
      idx = (int'(start) + k) % CH_NUM;
      if (cand[idx]) r = IW'(idx);
    end
    return r;
  endfunction

  function automatic logic [IW-1:0] rr_next(
    input logic [IW-1:0] i
  );
    return (int'(i) == CH_NUM - 1) ? '0 : i + 1'b1;
  endfunction

  always_comb begin
    for (int c = 0; c < CH_NUM; c++) begin
      weff[c] = eff_len(wptr_q[c],
        wr_e_addr[c*ADDR_W +: ADDR_W], wr_burst_len);
      reff[c] = eff_len(rptr_q[c],
        rd_e_addr[c*ADDR_W +: ADDR_W], rd_burst_len);
      wcand[c] = init_end & ~wr_rst[c] &
        (weff[c] != '0) &
        (32'(wr_fifo_num[c*CNT_W +: CNT_W]) >= 32'(weff[c]));
      rcand[c] = init_end & read_valid[c] & ~rd_rst[c] &
        (reff[c] != '0) &
        (32'(rd_fifo_num[c*CNT_W +: CNT_W]) < 32'(rd_burst_len));
    end
    wpick = pick(wcand, (RR_EN != 0) ? wrr_q : '0);
    rpick = pick(rcand, (RR_EN != 0) ? rrr_q : '0);
  end

  assign wr_end = (st_q == WR_BUSY) & wack_q & ~sd.sdram_wr_ack;
  assign rd_end = (st_q == RD_BUSY) & rack_q & ~sd.sdram_rd_ack;

  always_comb begin
    st_d    = st_q;
    wsel_d  = wsel_q;
    rsel_d  = rsel_q;
    wrr_d   = wrr_q;
    rrr_d   = rrr_q;
    waddr_d = waddr_q;
    raddr_d = raddr_q;
    wlen_d  = wlen_q;
    rlen_d  = rlen_q;
    wreq_d  = wreq_q;
    rreq_d  = rreq_q;

    // A reload during the granted burst cancels its end update.
    wdrop_d = (st_q == IDLE) ? 1'b0 : (wdrop_q | |(wr_rst & wsel_q));
    rdrop_d = (st_q == IDLE) ? 1'b0 : (rdrop_q | |(rd_rst & rsel_q));

    for (int c = 0; c < CH_NUM; c++) begin
      wptr_d[c] = wptr_q[c];
      rptr_d[c] = rptr_q[c];
      if (wr_rst[c] || weff[c] == '0)
        wptr_d[c] = wr_b_addr[c*ADDR_W +: ADDR_W];
      else if (wr_end && wsel_q[c] && !wdrop_q)
        wptr_d[c] = advance(wptr_q[c],
          wr_b_addr[c*ADDR_W +: ADDR_W],
          wr_e_addr[c*ADDR_W +: ADDR_W], wlen_q);
      if (rd_rst[c] || reff[c] == '0)
        rptr_d[c] = rd_b_addr[c*ADDR_W +: ADDR_W];
      else if (rd_end && rsel_q[c] && !rdrop_q)
        rptr_d[c] = advance(rptr_q[c],
          rd_b_addr[c*ADDR_W +: ADDR_W],
          rd_e_addr[c*ADDR_W +: ADDR_W], rlen_q);
    end

    unique case (st_q)
      IDLE: begin
        if (|wcand) begin
          wsel_d  = CH_NUM'(1) << wpick;
          waddr_d = wptr_q[wpick];
          wlen_d  = weff[wpick];
          wreq_d  = 1'b1;
          wrr_d   = rr_next(wpick);
          st_d    = WR_REQ;
        end else if (|rcand) begin
          rsel_d  = CH_NUM'(1) << rpick;
          raddr_d = rptr_q[rpick];
          rlen_d  = reff[rpick];
          rreq_d  = 1'b1;
          rrr_d   = rr_next(rpick);
          st_d    = RD_REQ;
        end
      end
      WR_REQ: if (sd.sdram_wr_ack) begin
        wreq_d = 1'b0;
        st_d   = WR_BUSY;
      end
      WR_BUSY: if (wr_end) begin
        wsel_d = '0;
        st_d   = IDLE;
      end
      RD_REQ: if (sd.sdram_rd_ack) begin
        rreq_d = 1'b0;
        st_d   = RD_BUSY;
      end
      RD_BUSY: if (rd_end) begin
        rsel_d = '0;
        st_d   = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      st_q    <= IDLE;
      wsel_q  <= '0;
      rsel_q  <= '0;
      wrr_q   <= '0;
      rrr_q   <= '0;
      waddr_q <= '0;
      raddr_q <= '0;
      wlen_q  <= '0;
      rlen_q  <= '0;
      wreq_q  <= 1'b0;
      rreq_q  <= 1'b0;
      wack_q  <= 1'b0;
      rack_q  <= 1'b0;
      wdrop_q <= 1'b0;
      rdrop_q <= 1'b0;
      for (int c = 0; c < CH_NUM; c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
      end
    end else begin
      st_q    <= st_d;
      wsel_q  <= wsel_d;
      rsel_q  <= rsel_d;
      wrr_q   <= wrr_d;
      rrr_q   <= rrr_d;
      waddr_q <= waddr_d;
      raddr_q <= raddr_d;
      wlen_q  <= wlen_d;
      rlen_q  <= rlen_d;
      wreq_q  <= wreq_d;
      rreq_q  <= rreq_d;
      wack_q  <= sd.sdram_wr_ack;
      rack_q  <= sd.sdram_rd_ack;
      wdrop_q <= wdrop_d;
      rdrop_q <= rdrop_d;
      for (int c = 0; c < CH_NUM; c++) begin
        wptr_q[c] <= wptr_d[c];
        rptr_q[c] <= rptr_d[c];
      end
    end
  end

  assign sd.sdram_wr_req  = wreq_q;
  assign sd.sdram_wr_addr = waddr_q;
  assign sd.sdram_wr_len  = wlen_q;
  assign sd.sdram_rd_req  = rreq_q;
  assign sd.sdram_rd_addr = raddr_q;
  assign sd.sdram_rd_len  = rlen_q;
  assign wr_ch_sel        = wsel_q;
  assign rd_ch_sel        = rsel_q;
  assign wr_fifo_rd_en    = {CH_NUM{sd.sdram_wr_ack}} & wsel_q;
  assign rd_fifo_wr_en    = {CH_NUM{sd.sdram_rd_ack}} & rsel_q;

endmodule
